fifo_stream_reader: RTL and testbench

- Read-side master for the registered 32-bit FIFO wrapper. Issues rdreq_o against a FIFO whose flags and read data arrive through pipeline registers.
- Compensates for stale usedw_i and for read latency. Captures returned words into a small internal skid buffer and presents them as a valid/ready stream to the downstream consumer.
- Never over-reads the FIFO. Never overflows its own buffer.

---
 rtl/fifo_stream_reader.sv | 104 ++++++++++
 tb/tb_fifo_stream_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side master for a registered FIFO: issues credit-limited reads, absorbs read
// latency in a small skid buffer, and presents the words as a valid/ready stream.
module fifo_stream_reader #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 10,
  parameter int RD_LAT    = 3,
  parameter int FLAG_LAT  = 3,
  parameter int BUF_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         arst_n_i,
  input  logic                         en_i,
  input  logic [AWIDTH:0]              usedw_i,
  input  logic [DWIDTH-1:0]            data_i,
  output logic                         rdreq_o,
  output logic                         valid_o,
  output logic [DWIDTH-1:0]            data_o,
  input  logic                         ready_i,
  output logic [$clog2(BUF_DEPTH):0]   buf_cnt_o,
  output logic                         ovf_err_o
);

  localparam int PW    = $clog2(BUF_DEPTH);
  localparam int CNTW  = PW + 1;
  localparam int UW    = AWIDTH + 1;
  localparam int ISS_W = (FLAG_LAT > 1) ? FLAG_LAT - 1 : 1;
  localparam int SW    = $clog2(BUF_DEPTH + RD_LAT + 1) + 1;

  logic [ISS_W-1:0]  iss_q, iss_d;
  logic [RD_LAT-1:0] ret_q, ret_d;
  logic [DWIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [AWIDTH:0]   pend;
  logic [SW-1:0]     infl, used;
  logic              capture, pop, wr_en, rdreq;

  assign valid_o = (cnt_q != '0);
  assign pop     = valid_o & ready_i;
  assign capture = ret_q[RD_LAT-1];

  // NOTE: every always_comb output gets a default before any conditional logic,
  // so no path can leave a signal unassigned and infer a latch.
  always_comb begin
    pend = '0;
    if (FLAG_LAT > 1) begin
      for (int i = 0; i < ISS_W; i++) pend = pend + UW'(iss_q[i]);
    end
    infl = '0;
    for (int i = 0; i < RD_LAT; i++) infl = infl + SW'(ret_q[i]);

    // A pop at this edge frees an entry, so it is credited; this is what lets a
    // buffer of RD_LAT+1 entries sustain one read per cycle.
    used  = SW'(cnt_q) + infl - SW'(pop);
    rdreq = arst_n_i & en_i & (usedw_i > pend) & (used < SW'(BUF_DEPTH));

    iss_d    = '0;
    iss_d[0] = rdreq;
    for (int i = 1; i < ISS_W; i++) iss_d[i] = iss_q[i-1];
    ret_d    = '0;
    ret_d[0] = rdreq;
    for (int i = 1; i < RD_LAT; i++) ret_d[i] = ret_q[i-1];

    wr_en    = capture & ((cnt_q != CNTW'(BUF_DEPTH)) | pop);
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CNTW'(wr_en) - CNTW'(pop);
    ovf_d    = ovf_q | (capture & ~wr_en);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      iss_q    <= '0;
      ret_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      iss_q    <= iss_d;
      ret_q    <= ret_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: the storage array has no reset; stale entries are never observable
  // because data_o is forced to zero whenever the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o    = valid_o ? mem_q[rd_ptr_q] : '0;
  assign rdreq_o   = rdreq;
  assign buf_cnt_o = cnt_q;
  assign ovf_err_o = ovf_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader against a behavioural FIFO whose data and
// fill level both trail a read by three cycles.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk_i    = 1'b0;
  logic          arst_n_i = 1'b0;
  logic          en_i     = 1'b0;
  logic          ready_i  = 1'b0;
  logic [AW:0]   usedw_i  = '0;
  logic [DW-1:0] data_i   = '0;
  logic          rdreq_o, valid_o, ovf_err_o;
  logic [DW-1:0] data_o;
  logic [2:0]    buf_cnt_o;

  fifo_stream_reader dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .en_i(en_i), .usedw_i(usedw_i),
    .data_i(data_i), .rdreq_o(rdreq_o), .valid_o(valid_o), .data_o(data_o),
    .ready_i(ready_i), .buf_cnt_o(buf_cnt_o), .ovf_err_o(ovf_err_o)
  );

  always #5 clk_i = ~clk_i;

  // FIFO model: word k of a load is base+k; count and data each trail a read by 3 cycles
  logic          load      = 1'b0;
  int            load_cnt  = 0;
  logic [31:0]   load_base = '0;
  int            f_cnt     = 0;
  logic [31:0]   next_word = '0;
  logic [AW:0]   u1        = '0;
  logic          underrun  = 1'b0;
  logic [31:0]   d1 = '0, d2 = '0;

  always @(posedge clk_i) begin
    if (load) begin
      f_cnt     <= load_cnt;
      next_word <= load_base;
      underrun  <= 1'b0;
    end else if (rdreq_o) begin
      if (f_cnt == 0) underrun <= 1'b1;
      else begin
        f_cnt     <= f_cnt - 1;
        next_word <= next_word + 1;
      end
    end
    u1      <= f_cnt[AW:0];
    usedw_i <= u1;
  end

  always @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      d1 <= '0; d2 <= '0; data_i <= '0;
    end else begin
      d1 <= next_word; d2 <= d1; data_i <= d2;
    end
  end

  int          checks = 0, failures = 0;
  int          rd_cnt, step_idx, stab_err;
  logic [31:0] got[$];
  logic        trace_rd[256], trace_v[256];
  logic        hold_prev;
  logic [31:0] hold_data;

  task automatic clear_log();
    rd_cnt = 0; step_idx = 0; stab_err = 0; hold_prev = 1'b0; hold_data = '0;
    got.delete();
  endtask

  task automatic record();
    if (rdreq_o) rd_cnt++;
    if (step_idx < 256) begin
      trace_rd[step_idx] = rdreq_o;
      trace_v[step_idx]  = valid_o;
    end
    if (hold_prev && (!valid_o || data_o !== hold_data)) stab_err++;
    hold_prev = valid_o && !ready_i;
    hold_data = data_o;
    if (valid_o && ready_i) got.push_back(data_o);
    step_idx++;
  endtask

  // Inputs are set just after a falling edge; outputs are sampled before the next rising edge.
  task automatic step();
    #1;
    record();
    @(negedge clk_i);
  endtask

  task automatic do_reset(input int n, input logic [31:0] base);
    arst_n_i = 1'b0; en_i = 1'b0; ready_i = 1'b0;
    load_cnt = n; load_base = base; load = 1'b1;
    step();
    load = 1'b0;
    repeat (4) step();
    arst_n_i = 1'b1;
    clear_log();
  endtask

  function automatic int order_errors(input logic [31:0] base, input int n);
    int e = 0;
    if (got.size() != n) e++;
    for (int i = 0; i < got.size(); i++) if (got[i] !== base + 32'(i)) e++;
    return e;
  endfunction

  task automatic test_reset();
    arst_n_i = 1'b0; en_i = 1'b0; ready_i = 1'b1;
    load_cnt = 5; load_base = 32'hB0; load = 1'b1;
    step();
    load = 1'b0; en_i = 1'b1;
    repeat (4) step();
    #1;
    checks++; if (rdreq_o !== 1'b0) begin failures++; $display("FAIL reset_rdreq: got %b expected 0", rdreq_o); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    checks++; if (buf_cnt_o !== 3'd0) begin failures++; $display("FAIL reset_buf_cnt: got %0d expected 0", buf_cnt_o); end
    checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", data_o); end
    checks++; if (ovf_err_o !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", ovf_err_o); end
    @(negedge clk_i);
    arst_n_i = 1'b1;
    clear_log();
    repeat (4) step();
    #1;
    checks++; if (valid_o !== 1'b1 || data_o !== 32'hB0) begin failures++; $display("FAIL prereset_head: got valid=%b data=%h expected valid=1 data=b0", valid_o, data_o); end
    checks++; if (rdreq_o !== 1'b1) begin failures++; $display("FAIL prereset_rdreq: got %b expected 1", rdreq_o); end
    #1 arst_n_i = 1'b0;
    #1;
    checks++; if (rdreq_o !== 1'b0) begin failures++; $display("FAIL async_rdreq: got %b expected 0", rdreq_o); end
    checks++; if (valid_o !== 1'b0 || buf_cnt_o !== 3'd0) begin failures++; $display("FAIL async_clear: got valid=%b cnt=%0d expected valid=0 cnt=0", valid_o, buf_cnt_o); end
    checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL async_data: got %h expected 0", data_o); end
  endtask

  task automatic test_stale_flag();
    do_reset(2, 32'hA0);
    en_i = 1'b1; ready_i = 1'b1;
    repeat (12) step();
    checks++; if (rd_cnt != 2) begin failures++; $display("FAIL stale_reads: got %0d expected 2", rd_cnt); end
    checks++; if (trace_rd[0] !== 1'b1 || trace_rd[1] !== 1'b1 || trace_rd[2] !== 1'b0) begin failures++; $display("FAIL stale_pattern: got %b%b%b expected 110", trace_rd[0], trace_rd[1], trace_rd[2]); end
    checks++; if (order_errors(32'hA0, 2) != 0) begin failures++; $display("FAIL stale_words: got %0d words, %0d errors expected A0,A1", got.size(), order_errors(32'hA0, 2)); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL stale_underrun: got %b expected 0", underrun); end
  endtask

  task automatic test_streaming();
    int n_rd, vbad;
    do_reset(100, 32'h0);
    en_i = 1'b1; ready_i = 1'b1;
    repeat (110) step();
    n_rd = 0; vbad = 0;
    for (int i = 0; i < 100; i++) if (trace_rd[i] === 1'b1) n_rd++;
    for (int i = 0; i < 4; i++) if (trace_v[i] !== 1'b0) vbad++;
    for (int i = 4; i < 104; i++) if (trace_v[i] !== 1'b1) vbad++;
    if (trace_v[104] !== 1'b0) vbad++;
    checks++; if (n_rd != 100 || rd_cnt != 100) begin failures++; $display("FAIL stream_rdreq: got %0d in first 100, %0d total expected 100,100", n_rd, rd_cnt); end
    checks++; if (vbad != 0) begin failures++; $display("FAIL stream_valid: got %0d bad cycles expected 0", vbad); end
    checks++; if (order_errors(32'h0, 100) != 0) begin failures++; $display("FAIL stream_order: got %0d words, %0d errors expected 0..99", got.size(), order_errors(32'h0, 100)); end
    checks++; if (ovf_err_o !== 1'b0 || underrun !== 1'b0) begin failures++; $display("FAIL stream_errs: got ovf=%b underrun=%b expected 0,0", ovf_err_o, underrun); end
  endtask

  task automatic test_backpressure();
    do_reset(20, 32'h100);
    en_i = 1'b1; ready_i = 1'b0;
    repeat (10) step();
    #1;
    checks++; if (rd_cnt != 4) begin failures++; $display("FAIL bp_reads: got %0d expected 4", rd_cnt); end
    checks++; if (buf_cnt_o !== 3'd4 || rdreq_o !== 1'b0) begin failures++; $display("FAIL bp_full: got cnt=%0d rdreq=%b expected 4,0", buf_cnt_o, rdreq_o); end
    checks++; if (data_o !== 32'h100) begin failures++; $display("FAIL bp_head: got %h expected 100", data_o); end
    for (int i = 0; i < 80; i++) begin
      ready_i = (i % 2 == 0);
      step();
    end
    ready_i = 1'b0;
    #1;
    checks++; if (order_errors(32'h100, 20) != 0) begin failures++; $display("FAIL bp_order: got %0d words, %0d errors expected 100..113", got.size(), order_errors(32'h100, 20)); end
    checks++; if (stab_err != 0) begin failures++; $display("FAIL bp_stable: got %0d changes while stalled expected 0", stab_err); end
    checks++; if (rd_cnt != 20 || buf_cnt_o !== 3'd0) begin failures++; $display("FAIL bp_drain: got reads=%0d cnt=%0d expected 20,0", rd_cnt, buf_cnt_o); end
    checks++; if (ovf_err_o !== 1'b0 || underrun !== 1'b0) begin failures++; $display("FAIL bp_errs: got ovf=%b underrun=%b expected 0,0", ovf_err_o, underrun); end
  endtask

  task automatic test_en_gating();
    int n_rd;
    do_reset(10, 32'h200);
    ready_i = 1'b1; en_i = 1'b1;
    step(); step();
    en_i = 1'b0;
    repeat (10) step();
    n_rd = 0;
    for (int i = 2; i < 12; i++) if (trace_rd[i] !== 1'b0) n_rd++;
    checks++; if (rd_cnt != 2 || n_rd != 0) begin failures++; $display("FAIL en_reads: got %0d total, %0d while disabled expected 2,0", rd_cnt, n_rd); end
    checks++; if (trace_v[4] !== 1'b1 || trace_v[5] !== 1'b1 || trace_v[6] !== 1'b0) begin failures++; $display("FAIL en_land: got %b%b%b expected 110", trace_v[4], trace_v[5], trace_v[6]); end
    checks++; if (order_errors(32'h200, 2) != 0) begin failures++; $display("FAIL en_words: got %0d words, %0d errors expected 200,201", got.size(), order_errors(32'h200, 2)); end
    en_i = 1'b1;
    repeat (20) step();
    checks++; if (rd_cnt != 10 || order_errors(32'h200, 10) != 0) begin failures++; $display("FAIL en_resume: got reads=%0d words=%0d expected 10,10 in order", rd_cnt, got.size()); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL en_underrun: got %b expected 0", underrun); end
  endtask

  // The credit rule keeps occupancy plus in-flight at or below 4, so the fullest
  // reachable capture-with-pop happens at occupancy 3.
  task automatic test_simul_capture_pop();
    do_reset(8, 32'h300);
    en_i = 1'b1; ready_i = 1'b0;
    repeat (8) step();
    #1;
    checks++; if (buf_cnt_o !== 3'd4) begin failures++; $display("FAIL sim_fill: got %0d expected 4", buf_cnt_o); end
    ready_i = 1'b1; step();
    ready_i = 1'b0; step(); step();
    #1;
    checks++; if (buf_cnt_o !== 3'd3 || data_o !== 32'h301) begin failures++; $display("FAIL sim_before: got cnt=%0d data=%h expected 3,301", buf_cnt_o, data_o); end
    ready_i = 1'b1; step();
    ready_i = 1'b0;
    #1;
    checks++; if (buf_cnt_o !== 3'd3 || data_o !== 32'h302) begin failures++; $display("FAIL sim_after: got cnt=%0d data=%h expected 3,302", buf_cnt_o, data_o); end
    ready_i = 1'b1;
    repeat (15) step();
    checks++; if (order_errors(32'h300, 8) != 0) begin failures++; $display("FAIL sim_order: got %0d words, %0d errors expected 300..307", got.size(), order_errors(32'h300, 8)); end
    checks++; if (ovf_err_o !== 1'b0 || underrun !== 1'b0) begin failures++; $display("FAIL sim_errs: got ovf=%b underrun=%b expected 0,0", ovf_err_o, underrun); end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_stale_flag();
    test_streaming();
    test_backpressure();
    test_en_gating();
    test_simul_capture_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
